// File: rtl/trdb_output_ctrl.sv
// rtl/trdb_output_ctrl.sv - trace/sw-dump word arbiter, output FIFO, uDMA drain and flush sequencer
//
// Purpose:
//    Merges aligned trace packet words (no backpressure, fixed priority) and
//    software-dump words (valid/grant) into one FIFO, drains the FIFO to the
//    uDMA over valid/ready, sequences register-triggered flushes with a
//    4-phase req/done handshake and counts trace words lost to overflow.
//
// Ports:
//    clk_i, rst_i              clock, asynchronous active-high reset
//    trace_word_i/valid_i      trace word, single-cycle strobe
//    sw_word_i/valid_i         sw-dump word, held until sw_grant_o
//    sw_grant_o                sw word accepted this cycle (combinational)
//    flush_req_i/done_o        flush request level / registered completion
//    udma_data_o/valid_o       FIFO head toward the uDMA
//    udma_ready_i              uDMA accepts the head word
//    fifo_level_o              occupancy after the previous edge
//    overflow_o/cnt_o          sticky drop flag / saturating drop counter
//    clear_i                   clears the overflow flag and counter
module trdb_output_ctrl #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [XLEN-1:0]               trace_word_i,
   input  logic                          trace_valid_i,
   input  logic [XLEN-1:0]               sw_word_i,
   input  logic                          sw_valid_i,
   output logic                          sw_grant_o,
   input  logic                          flush_req_i,
   output logic                          flush_done_o,
   output logic [XLEN-1:0]               udma_data_o,
   output logic                          udma_valid_o,
   input  logic                          udma_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   output logic [CNT_WIDTH-1:0]          overflow_cnt_o,
   input  logic                          clear_i
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]        DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [XLEN-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [LW-1:0]   level;

   logic            pop, space, push, trace_push, drop;
   logic [XLEN-1:0] push_data;

   // Handshake and arbitration.  A full FIFO still has space when the head
   // leaves in the same cycle.
   assign pop        = udma_valid_o && udma_ready_i;
   assign space      = (level != DEPTH_L) || pop;
   assign trace_push = trace_valid_i && space;
   assign drop       = trace_valid_i && !space;
   assign sw_grant_o = sw_valid_i && !trace_valid_i && space && (state != DRAIN);
   assign push       = trace_push || sw_grant_o;
   assign push_data  = trace_valid_i ? trace_word_i : sw_word_i;

   // Output side comes only from registered storage and the level counter.
   assign udma_valid_o = (level != '0);
   assign udma_data_o  = mem[rd_ptr];
   assign fifo_level_o = level;
   assign flush_done_o = (state == DONE);

   // Storage and pointers.  Power-of-two depth lets pointers wrap naturally;
   // full/empty come from the level counter alone.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Overflow bookkeeping.  A drop in the same cycle as a clear restarts the
   // count at one so that the lost word is never hidden.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o     <= 1'b0;
         overflow_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (clear_i) begin
            overflow_cnt_o <= CNT_WIDTH'(1);
         end else if (overflow_cnt_o != CNT_MAX) begin
            overflow_cnt_o <= overflow_cnt_o + CNT_WIDTH'(1);
         end
      end else if (clear_i) begin
         overflow_o     <= 1'b0;
         overflow_cnt_o <= '0;
      end
   end

   // Flush sequencer state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DRAIN completes only when nothing is buffered and no trace word is
   // arriving, so DONE is never entered with a word about to land.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (flush_req_i) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!flush_req_i) begin
               state_next = IDLE;
            end else if ((level == '0) && !trace_valid_i) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!flush_req_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_trdb_output_ctrl.sv
// tb/tb_trdb_output_ctrl.sv - self-checking bench for trdb_output_ctrl
module tb_trdb_output_ctrl;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] trace_word, sw_word, udma_data;
   logic            trace_valid, sw_valid, sw_grant;
   logic            flush_req, flush_done, udma_valid, udma_ready;
   logic [3:0]      fifo_level;
   logic            overflow, clear;
   logic [CW-1:0]   overflow_cnt;

   trdb_output_ctrl #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .trace_word_i   (trace_word),
      .trace_valid_i  (trace_valid),
      .sw_word_i      (sw_word),
      .sw_valid_i     (sw_valid),
      .sw_grant_o     (sw_grant),
      .flush_req_i    (flush_req),
      .flush_done_o   (flush_done),
      .udma_data_o    (udma_data),
      .udma_valid_o   (udma_valid),
      .udma_ready_i   (udma_ready),
      .fifo_level_o   (fifo_level),
      .overflow_o     (overflow),
      .overflow_cnt_o (overflow_cnt),
      .clear_i        (clear)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: word queue, drop count, sticky flag, flush phase
   // (0 = no flush, 1 = waiting for empty, 2 = completed).
   logic [XLEN-1:0] q[$];
   int  m_cnt;
   bit  m_flag;
   int  m_phase;
   bit  last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt   = 0;
      m_flag  = 0;
      m_phase = 0;
   endtask

   // Entered just after a falling edge with inputs already driven; checks
   // all outputs against the model, advances both across one rising edge.
   task automatic cycle();
      int lvl;
      bit pop, sp, grant;
      #1;
      lvl   = q.size();
      pop   = (lvl != 0) && udma_ready;
      sp    = (lvl < DEPTH) || pop;
      grant = sw_valid && !trace_valid && sp && (m_phase != 1);
      chk("level", 32'(fifo_level), 32'(lvl));
      chk("valid", 32'(udma_valid), 32'(lvl != 0));
      if (lvl != 0) chk("data", udma_data, q[0]);
      chk("done", 32'(flush_done), 32'(m_phase == 2));
      chk("ovf_flag", 32'(overflow), 32'(m_flag));
      chk("ovf_cnt", 32'(overflow_cnt), 32'(m_cnt));
      chk("grant", 32'(sw_grant), 32'(grant));
      last_grant = grant;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (trace_valid && sp) q.push_back(trace_word);
      else if (grant) q.push_back(sw_word);
      if (trace_valid && !sp) begin
         m_flag = 1;
         m_cnt  = clear ? 1 : ((m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1);
      end else if (clear) begin
         m_flag = 0;
         m_cnt  = 0;
      end
      case (m_phase)
         0: if (flush_req) m_phase = 1;
         1: if (!flush_req) m_phase = 0;
            else if (lvl == 0 && !trace_valid) m_phase = 2;
         default: if (!flush_req) m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      trace_valid = 0; sw_valid = 0; clear = 0; flush_req = 0; udma_ready = 0;
      trace_word = '0; sw_word = '0;
   endtask

   task automatic trace(input logic [31:0] w, input bit rdy);
      trace_valid = 1; trace_word = w; udma_ready = rdy;
      cycle();
      trace_valid = 0;
   endtask

   task automatic drain_all();
      udma_ready = 1;
      for (int i = 0; i < DEPTH + 2; i++) cycle();
      udma_ready = 0;
      clear = 1;
      cycle();
      clear = 0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst = 1;
      #1;
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_valid", 32'(udma_valid), 0);
      chk("rst_data", udma_data, 0);
      chk("rst_done", 32'(flush_done), 0);
      chk("rst_cnt", 32'(overflow_cnt), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      // Basic: three back-to-back trace words drained at once.
      for (int i = 0; i < 3; i++) trace(32'hA000_0000 + i, 1);
      chk("basic_level_peak", 32'(fifo_level), 1);
      udma_ready = 1;
      cycle();
      cycle();
      chk("basic_cnt", 32'(overflow_cnt), 0);

      // Arbitration: sw held while trace is present for two cycles.
      sw_valid = 1; sw_word = 32'h5555_0001;
      trace(32'hB000_0000, 0);
      chk("arb_grant0", 32'(last_grant), 0);
      sw_valid = 1;
      trace(32'hB000_0001, 0);
      chk("arb_grant1", 32'(last_grant), 0);
      cycle();
      chk("arb_grant2", 32'(last_grant), 1);
      sw_valid = 0;
      drain_all();

      // Overflow: ten words into eight slots, then clear vs drop, then a
      // pop-and-push on a full FIFO.
      for (int i = 0; i < 10; i++) trace(32'hC000_0000 + i, 0);
      chk("ovf_level", 32'(fifo_level), 8);
      chk("ovf_cnt2", 32'(overflow_cnt), 2);
      chk("ovf_flag1", 32'(overflow), 1);
      clear = 1;
      trace(32'hC000_000A, 0);
      clear = 0;
      chk("ovf_clear_drop", 32'(overflow_cnt), 1);
      trace(32'hC000_000B, 1);
      chk("full_swap_level", 32'(fifo_level), 8);
      chk("full_swap_cnt", 32'(overflow_cnt), 1);

      // Saturation: twenty more drops on a full FIFO.
      for (int i = 0; i < 20; i++) trace(32'hD000_0000 + i, 0);
      chk("sat_cnt", 32'(overflow_cnt), 15);
      drain_all();

      // Flush with a pending sw word and a toggling ready.
      for (int i = 0; i < 5; i++) trace(32'hE000_0000 + i, 0);
      flush_req = 1; sw_valid = 1; sw_word = 32'h5555_0002;
      cycle();
      for (int i = 0; i < 30 && m_phase != 2; i++) begin
         udma_ready = i[0] ? 1'b0 : 1'b1;
         cycle();
         if (m_phase == 1) chk("flush_no_grant", 32'(last_grant), 0);
      end
      udma_ready = 0;
      sw_valid = 0;
      cycle();
      chk("flush_done_hi", 32'(flush_done), 1);
      chk("flush_empty", 32'(fifo_level), 0);
      sw_valid = 1;
      flush_req = 0;
      cycle();
      chk("flush_grant", 32'(last_grant), 1);
      sw_valid = 0;
      cycle();
      chk("flush_done_lo", 32'(flush_done), 0);
      drain_all();

      // Empty FIFO flush: done two cycles after the request.
      flush_req = 1;
      cycle();
      cycle();
      chk("quick_done", 32'(flush_done), 1);
      flush_req = 0;
      cycle();

      // Reset in the middle of a flush.
      for (int i = 0; i < 4; i++) trace(32'hF000_0000 + i, 0);
      flush_req = 1;
      cycle();
      rst = 1;
      #1;
      chk("mid_rst_level", 32'(fifo_level), 0);
      chk("mid_rst_valid", 32'(udma_valid), 0);
      chk("mid_rst_done", 32'(flush_done), 0);
      model_reset();
      flush_req = 0;
      @(negedge clk);
      rst = 0;
      cycle();

      // Randomized traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         if (last_grant) sw_valid = 0;
         if (!sw_valid && $urandom_range(0, 2) == 0) begin
            sw_valid = 1;
            sw_word  = $urandom;
         end
         trace_valid = ($urandom_range(0, 9) < 4);
         trace_word  = $urandom;
         udma_ready  = ($urandom_range(0, 9) < 4);
         clear       = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
